// File: rtl/cacheline_arbiter_if.sv
// Bundle of the I-cache, D-cache and adaptor-facing cacheline signals around the arbiter.
// The master modport is the arbiter's view; slave is the surrounding caches and adaptor.
interface cacheline_arbiter_if #(
    parameter int size = 256
);
    logic              i_read;
    logic [31:0]       i_address;
    logic [size-1:0]   i_line_o;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [31:0]       d_address;
    logic [size-1:0]   d_line_i;
    logic [size-1:0]   d_line_o;
    logic              d_resp;

    logic [size-1:0]   line_o;
    logic [size-1:0]   line_i;
    logic [31:0]       address_o;
    logic              read_o;
    logic              write_o;
    logic              resp_i;

    modport master (
        input  i_read, i_address, d_read, d_write, d_address, d_line_i, line_i, resp_i,
        output i_line_o, i_resp, d_line_o, d_resp, line_o, address_o, read_o, write_o
    );

    modport slave (
        output i_read, i_address, d_read, d_write, d_address, d_line_i, line_i, resp_i,
        input  i_line_o, i_resp, d_line_o, d_resp, line_o, address_o, read_o, write_o
    );
endinterface

// File: rtl/cacheline_arbiter.sv
// Grants the single adaptor cacheline port to the I-cache or D-cache one whole line at a time,
// with round-robin (or fixed I priority) on contention and a one-cycle recovery gap after each response.
module cacheline_arbiter #(
    parameter int s_offset    = 5,
    parameter int size        = (2**s_offset)*8,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    cacheline_arbiter_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        GRANT_I,
        GRANT_D_RD,
        GRANT_D_WR,
        RECOVER
    } state_t;

    state_t            state;
    logic              last_served_d;
    logic [31:0]       address_q;
    logic [size-1:0]   line_q;
    logic              read_q;
    logic              write_q;

    logic              d_req;
    logic              pick_i;
    logic              in_grant_i;
    logic              in_grant_d;

    // I wins when D is not asking, when priority is fixed, or when D was the last one served.
    always_comb begin
        d_req      = bus.d_read | bus.d_write;
        pick_i     = bus.i_read & (~d_req | ~ROUND_ROBIN | last_served_d);
        in_grant_i = (state == GRANT_I);
        in_grant_d = (state == GRANT_D_RD) | (state == GRANT_D_WR);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            last_served_d <= 1'b1;
            address_q     <= '0;
            line_q        <= '0;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_i) begin
                        state         <= GRANT_I;
                        address_q     <= bus.i_address;
                        last_served_d <= 1'b0;
                        read_q        <= 1'b1;
                    end else if (d_req) begin
                        address_q     <= bus.d_address;
                        last_served_d <= 1'b1;
                        if (bus.d_read) begin
                            state  <= GRANT_D_RD;
                            read_q <= 1'b1;
                        end else begin
                            state   <= GRANT_D_WR;
                            write_q <= 1'b1;
                            line_q  <= bus.d_line_i;
                        end
                    end
                end
                GRANT_I, GRANT_D_RD, GRANT_D_WR: begin
                    if (bus.resp_i) begin
                        state   <= RECOVER;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                    end
                end
                // Keeps the adaptor's post-done cycle quiet and stops a lingering request being re-granted.
                RECOVER: state <= IDLE;
                default: begin
                    state   <= IDLE;
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.address_o = address_q;
    assign bus.line_o    = line_q;
    assign bus.read_o    = read_q;
    assign bus.write_o   = write_q;
    assign bus.i_resp    = in_grant_i & bus.resp_i;
    assign bus.d_resp    = in_grant_d & bus.resp_i;
    assign bus.i_line_o  = bus.line_i;
    assign bus.d_line_o  = bus.line_i;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed bench for cacheline_arbiter: a round-robin and a fixed-priority instance share client
// stimulus, each with its own adaptor responder, and are compared every cycle to a transaction model.
module tb_cacheline_arbiter;

    localparam int SIZE = 256;
    localparam logic [SIZE-1:0] PAT_A = {8{32'h1111_A0A0}};
    localparam logic [SIZE-1:0] PAT_B = {8{32'hBEEF_0B0B}};
    localparam logic [SIZE-1:0] PAT_C = {8{32'h0C0C_C3C3}};

    logic            clk;
    logic            reset_n;
    logic            i_read;
    logic [31:0]     i_address;
    logic            d_read;
    logic            d_write;
    logic [31:0]     d_address;
    logic [SIZE-1:0] d_line_i;
    logic [SIZE-1:0] line_in;
    logic            force_resp;

    logic            read_w   [2];
    logic            write_w  [2];
    logic [31:0]     addr_w   [2];
    logic [SIZE-1:0] line_o_w [2];
    logic [SIZE-1:0] i_line_w [2];
    logic [SIZE-1:0] d_line_w [2];
    logic            i_resp_w [2];
    logic            d_resp_w [2];
    logic            resp_w   [2];

    int checks   = 0;
    int failures = 0;

    // Instance 0 alternates on contention, instance 1 always favours the I-cache.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        cacheline_arbiter_if #(.size(SIZE)) bus ();
        logic resp_q;
        int   cnt;

        cacheline_arbiter #(
            .s_offset(5),
            .ROUND_ROBIN(g == 0 ? 1'b1 : 1'b0)
        ) dut (
            .clk(clk),
            .reset_n(reset_n),
            .bus(bus)
        );

        assign bus.i_read    = i_read;
        assign bus.i_address = i_address;
        assign bus.d_read    = d_read;
        assign bus.d_write   = d_write;
        assign bus.d_address = d_address;
        assign bus.d_line_i  = d_line_i;
        assign bus.line_i    = line_in;
        assign bus.resp_i    = resp_q | force_resp;

        assign read_w[g]   = bus.read_o;
        assign write_w[g]  = bus.write_o;
        assign addr_w[g]   = bus.address_o;
        assign line_o_w[g] = bus.line_o;
        assign i_line_w[g] = bus.i_line_o;
        assign d_line_w[g] = bus.d_line_o;
        assign i_resp_w[g] = bus.i_resp;
        assign d_resp_w[g] = bus.d_resp;
        assign resp_w[g]   = bus.resp_i;

        // Adaptor stand-in: pulses done in the fourth cycle after a request is first seen.
        always @(posedge clk) begin
            if (!reset_n) begin
                resp_q <= 1'b0;
                cnt    <= 0;
            end else if ((bus.read_o | bus.write_o) && !resp_q) begin
                if (cnt == 3) begin
                    resp_q <= 1'b1;
                    cnt    <= 0;
                end else begin
                    cnt <= cnt + 1;
                end
            end else begin
                resp_q <= 1'b0;
            end
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Transaction model: who owns the port (0 none, 1 I, 2 D read, 3 D write), recovery flag, last winner.
    int              m_busy   [2];
    bit              m_rec    [2];
    bit              m_last_d [2];
    logic [31:0]     m_addr   [2];
    logic [SIZE-1:0] m_line   [2];
    bit              m_valid = 1'b0;

    function automatic int choose(int k);
        bit win_i;
        if (i_read && (d_read || d_write)) win_i = (k == 1) || m_last_d[k];
        else                               win_i = i_read;
        if (win_i)   return 1;
        if (d_read)  return 2;
        if (d_write) return 3;
        return 0;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                m_busy[k]   <= 0;
                m_rec[k]    <= 1'b0;
                m_last_d[k] <= 1'b1;
                m_addr[k]   <= '0;
                m_line[k]   <= '0;
            end else if (m_busy[k] != 0) begin
                if (resp_w[k]) begin
                    m_busy[k] <= 0;
                    m_rec[k]  <= 1'b1;
                end
            end else if (m_rec[k]) begin
                m_rec[k] <= 1'b0;
            end else if (choose(k) != 0) begin
                m_busy[k]   <= choose(k);
                m_last_d[k] <= (choose(k) != 1);
                m_addr[k]   <= (choose(k) == 1) ? i_address : d_address;
                if (choose(k) == 3) m_line[k] <= d_line_i;
            end
        end
        if (!reset_n) m_valid <= 1'b1;
    end

    task automatic checkOutput(input string name, input logic [SIZE-1:0] act, input logic [SIZE-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                                 input logic [31:0] da, input logic [SIZE-1:0] dl);
        i_read    = ir;
        i_address = ia;
        d_read    = dr;
        d_write   = dw;
        d_address = da;
        d_line_i  = dl;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        applyStimulus(0, '0, 0, 0, '0, '0);
        tick(1);
        reset_n = 1'b1;
    endtask

    // Bounded wait on instance 0 for the chosen client's response; n is cycles waited.
    task automatic waitResp(input bit want_d, output int n);
        n = 0;
        while (!(want_d ? d_resp_w[0] : i_resp_w[0]) && n < 30) begin
            tick(1);
            n++;
        end
        checkOutput(want_d ? "d_resp_seen" : "i_resp_seen", SIZE'(n < 30), SIZE'(1));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [31:0] glog0[$];
    logic [31:0] glog1[$];
    bit          prev_act [2];

    initial begin
        int n;
        int base0;
        int base1;

        reset_n    = 1'b0;
        force_resp = 1'b0;
        line_in    = PAT_A;
        prev_act[0] = 1'b0;
        prev_act[1] = 1'b0;
        applyStimulus(0, '0, 0, 0, '0, '0);

        // Per-cycle comparison of both instances against the model, plus a log of grant addresses.
        fork
            forever begin
                @(negedge clk);
                if (m_valid) begin
                    for (int k = 0; k < 2; k++) begin
                        checkOutput($sformatf("read_o[%0d]", k), SIZE'(read_w[k]),
                                    SIZE'(m_busy[k] == 1 || m_busy[k] == 2));
                        checkOutput($sformatf("write_o[%0d]", k), SIZE'(write_w[k]), SIZE'(m_busy[k] == 3));
                        checkOutput($sformatf("address_o[%0d]", k), SIZE'(addr_w[k]), SIZE'(m_addr[k]));
                        checkOutput($sformatf("line_o[%0d]", k), line_o_w[k], m_line[k]);
                        checkOutput($sformatf("i_resp[%0d]", k), SIZE'(i_resp_w[k]),
                                    SIZE'(m_busy[k] == 1 && resp_w[k]));
                        checkOutput($sformatf("d_resp[%0d]", k), SIZE'(d_resp_w[k]),
                                    SIZE'(m_busy[k] >= 2 && resp_w[k]));
                        checkOutput($sformatf("i_line_o[%0d]", k), i_line_w[k], line_in);
                        checkOutput($sformatf("d_line_o[%0d]", k), d_line_w[k], line_in);
                    end
                end
                for (int k = 0; k < 2; k++) begin
                    if ((read_w[k] | write_w[k]) && !prev_act[k]) begin
                        if (k == 0) glog0.push_back(addr_w[k]);
                        else        glog1.push_back(addr_w[k]);
                    end
                    prev_act[k] = read_w[k] | write_w[k];
                end
            end
        join_none

        tick(2);
        reset_n = 1'b1;
        checkOutput("reset_read_o", SIZE'(read_w[0]), SIZE'(0));
        checkOutput("reset_write_o", SIZE'(write_w[0]), SIZE'(0));
        checkOutput("reset_address_o", SIZE'(addr_w[0]), SIZE'(0));

        // Plain I-cache read with line pattern A.
        applyStimulus(1, 32'h0000_1040, 0, 0, '0, '0);
        tick(1);
        checkOutput("i_grant_read_o", SIZE'(read_w[0]), SIZE'(1));
        checkOutput("i_grant_address", SIZE'(addr_w[0]), SIZE'(32'h0000_1040));
        waitResp(0, n);
        checkOutput("i_resp_latency", SIZE'(n), SIZE'(4));
        checkOutput("i_line_on_resp", i_line_w[0], PAT_A);
        checkOutput("d_resp_quiet", SIZE'(d_resp_w[0]), SIZE'(0));
        applyStimulus(0, 32'h0000_1040, 0, 0, '0, '0);
        tick(2);

        // D-cache writeback; data changed after the grant must not reach line_o.
        line_in = PAT_C;
        applyStimulus(0, '0, 0, 1, 32'h8000_0020, PAT_B);
        tick(1);
        checkOutput("d_wr_write_o", SIZE'(write_w[0]), SIZE'(1));
        checkOutput("d_wr_read_o", SIZE'(read_w[0]), SIZE'(0));
        checkOutput("d_wr_line_o", line_o_w[0], PAT_B);
        applyStimulus(0, '0, 0, 1, 32'h8000_0020, PAT_C);
        tick(1);
        checkOutput("d_wr_line_held", line_o_w[0], PAT_B);
        waitResp(1, n);
        checkOutput("d_wr_i_resp_quiet", SIZE'(i_resp_w[0]), SIZE'(0));
        applyStimulus(0, '0, 0, 0, '0, '0);
        tick(2);

        // Contention right after reset: I first, then D three cycles after I's response.
        doReset();
        base0 = glog0.size();
        applyStimulus(1, 32'h0000_2000, 1, 0, 32'h0000_3000, '0);
        tick(1);
        checkOutput("cont_first_addr", SIZE'(addr_w[0]), SIZE'(32'h0000_2000));
        waitResp(0, n);
        applyStimulus(0, 32'h0000_2000, 1, 0, 32'h0000_3000, '0);
        tick(2);
        checkOutput("cont_gap_read_o", SIZE'(read_w[0]), SIZE'(0));
        tick(1);
        checkOutput("cont_d_read_o", SIZE'(read_w[0]), SIZE'(1));
        checkOutput("cont_d_addr", SIZE'(addr_w[0]), SIZE'(32'h0000_3000));
        waitResp(1, n);
        applyStimulus(0, '0, 0, 0, '0, '0);
        tick(2);
        checkOutput("cont_log_len", SIZE'(glog0.size() - base0), SIZE'(2));
        checkOutput("cont_log_0", SIZE'(glog0[base0]), SIZE'(32'h0000_2000));
        checkOutput("cont_log_1", SIZE'(glog0[base0 + 1]), SIZE'(32'h0000_3000));

        // Both clients held for four grants: alternation vs fixed priority.
        doReset();
        base0 = glog0.size();
        base1 = glog1.size();
        applyStimulus(1, 32'h0000_4000, 1, 0, 32'h0000_5000, '0);
        n = 0;
        while ((glog0.size() - base0 < 4 || glog1.size() - base1 < 4) && n < 200) begin
            tick(1);
            n++;
        end
        checkOutput("hold_four_grants", SIZE'(n < 200), SIZE'(1));
        applyStimulus(0, '0, 0, 0, '0, '0);
        tick(10);
        for (int j = 0; j < 4; j++) begin
            checkOutput($sformatf("rr_grant_%0d", j), SIZE'(glog0[base0 + j]),
                        SIZE'(j % 2 == 0 ? 32'h0000_4000 : 32'h0000_5000));
            checkOutput($sformatf("fixed_grant_%0d", j), SIZE'(glog1[base1 + j]), SIZE'(32'h0000_4000));
        end

        // D request arriving mid I-grant waits until I finishes.
        doReset();
        applyStimulus(1, 32'h0000_6000, 0, 0, '0, '0);
        tick(1);
        applyStimulus(1, 32'h0000_6000, 1, 0, 32'h0000_7000, '0);
        tick(1);
        checkOutput("late_d_addr_kept", SIZE'(addr_w[0]), SIZE'(32'h0000_6000));
        checkOutput("late_d_read_o", SIZE'(read_w[0]), SIZE'(1));
        waitResp(0, n);
        applyStimulus(0, 32'h0000_6000, 1, 0, 32'h0000_7000, '0);
        tick(2);
        checkOutput("late_d_gap", SIZE'(read_w[0]), SIZE'(0));
        tick(1);
        checkOutput("late_d_granted", SIZE'(addr_w[0]), SIZE'(32'h0000_7000));
        waitResp(1, n);
        applyStimulus(0, '0, 0, 0, '0, '0);
        tick(2);

        // Reset in the middle of a writeback, then contention must favour I again.
        applyStimulus(0, '0, 0, 1, 32'h0000_9000, PAT_B);
        tick(1);
        checkOutput("pre_reset_write_o", SIZE'(write_w[0]), SIZE'(1));
        reset_n = 1'b0;
        tick(1);
        checkOutput("mid_reset_read_o", SIZE'(read_w[0]), SIZE'(0));
        checkOutput("mid_reset_write_o", SIZE'(write_w[0]), SIZE'(0));
        checkOutput("mid_reset_address", SIZE'(addr_w[0]), SIZE'(0));
        reset_n = 1'b1;
        applyStimulus(1, 32'h0000_A000, 0, 1, 32'h0000_B000, PAT_B);
        tick(1);
        checkOutput("post_reset_i_first", SIZE'(addr_w[0]), SIZE'(32'h0000_A000));
        checkOutput("post_reset_no_write", SIZE'(write_w[0]), SIZE'(0));
        waitResp(0, n);
        applyStimulus(0, '0, 0, 1, 32'h0000_B000, PAT_B);
        waitResp(1, n);
        applyStimulus(0, '0, 0, 0, '0, '0);
        tick(3);

        // A stray adaptor done while idle must not reach either client.
        force_resp = 1'b1;
        #1;
        checkOutput("stray_i_resp", SIZE'(i_resp_w[0]), SIZE'(0));
        checkOutput("stray_d_resp", SIZE'(d_resp_w[0]), SIZE'(0));
        tick(1);
        force_resp = 1'b0;
        applyStimulus(1, 32'h0000_C000, 0, 0, '0, '0);
        tick(1);
        checkOutput("after_stray_grant", SIZE'(addr_w[0]), SIZE'(32'h0000_C000));
        waitResp(0, n);
        applyStimulus(0, '0, 0, 0, '0, '0);
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cacheline_arbiter.md
Name: cacheline_arbiter

Overview:
- Two-client arbiter between the instruction cache (read-only) and the data cache (read/write) and the single cacheline port of the cacheline adaptor.
- Sits directly upstream of the adaptor and grants one whole-line transaction at a time.
- Latches the winner's address and write data, routes the adaptor's response back to the winner, then forces a one-cycle recovery gap before the next grant.
- Round-robin between the two clients when both request.

Parameters:
- s_offset, 5, log2 of cacheline bytes.
- size, (2**s_offset)*8, cacheline width in bits.
- ROUND_ROBIN, 1, 1 = alternate on contention; 0 = fixed priority, I-cache always wins.

Ports:
- clk  input  1  clock
- reset_n  input  1  reset; synchronous, active-low
- i_read  input  1  I-cache line read request, level, held until i_resp
- i_address  input  32  I-cache line address
- i_line_o  output  size  read line to I-cache
- i_resp  output  1  I-cache transaction complete
- d_read  input  1  D-cache line read request, level
- d_write  input  1  D-cache line write request, level
- d_address  input  32  D-cache line address
- d_line_i  input  size  D-cache writeback line
- d_line_o  output  size  read line to D-cache
- d_resp  output  1  D-cache transaction complete
- line_o  output  size  write line to adaptor
- line_i  input  size  read line from adaptor
- address_o  output  32  address to adaptor
- read_o  output  1  read request to adaptor
- write_o  output  1  write request to adaptor
- resp_i  input  1  adaptor done, one-cycle pulse

Behaviour:
- Reset (reset_n low at posedge clk):
  - State goes to IDLE; last_served goes to D, so I wins first contention.
  - address_o, line_o, read_o and write_o are all 0.
  - Reset wins over every other event in the same cycle, including an in-flight transaction; the adaptor is reset by the same signal.
- States: IDLE, GRANT_I, GRANT_D_RD, GRANT_D_WR, RECOVER.
- IDLE, request sampling:
  - I requesting only: go to GRANT_I.
  - D requesting only: go to GRANT_D_RD if d_read, otherwise GRANT_D_WR.
  - d_read and d_write both high: read takes priority.
  - Both clients requesting:
    - ROUND_ROBIN=1: grant the client not equal to last_served.
    - ROUND_ROBIN=0: grant I.
- On the transition out of IDLE:
  - Register the winner's address into address_o.
  - For GRANT_D_WR, register d_line_i into line_o; otherwise line_o holds its previous value.
  - Set last_served to the winner.
- read_o is 1 exactly in GRANT_I and GRANT_D_RD. write_o is 1 exactly in GRANT_D_WR. Both are state-decoded, glitch-free, and never both 1.
- Latency: request first seen high in IDLE at cycle t gives read_o/write_o high at t+1.
- Changes to the client's address or data after the grant have no effect.
- In any GRANT_* state with resp_i=1:
  - Combinationally assert the winner's resp (i_resp or d_resp) in that same cycle.
  - Next state is RECOVER. The loser's resp stays 0.
- i_line_o and d_line_o are both wired directly to line_i. Data is valid to the client in the cycle its resp is 1.
- RECOVER:
  - read_o and write_o are 0; lasts exactly one cycle, then IDLE.
  - Guarantees the adaptor sees no request in its post-DONE IDLE cycle.
  - Guarantees a client still holding its request one cycle after resp is not re-granted.
- Requests arriving while a grant is active are ignored until IDLE; no queueing, clients hold level.
- resp_i while in IDLE or RECOVER is a protocol error; ignore it, no state change, no client resp.
- Minimum turnaround: resp_i at cycle t → RECOVER at t+1 → IDLE at t+2 → next read_o/write_o at t+3.

Test Plan:
- i_read=1, i_address=0x0000_1040; resp_i pulsed 4 cycles after read_o rises with line_i=pattern A:
  - read_o=1 and address_o=0x0000_1040 one cycle after the request.
  - i_resp=1 and i_line_o=A in the resp_i cycle; d_resp=0.
- d_write=1, d_address=0x8000_0020, d_line_i=pattern B:
  - write_o=1, read_o=0, line_o=B.
  - Changing d_line_i after the grant does not alter line_o.
  - d_resp=1 on resp_i.
- i_read and d_read both high right after reset, ROUND_ROBIN=1:
  - I is served first, then RECOVER, then D granted at resp+3.
  - Address sequence: I address then D address.
- Both held continuously for 4 transactions:
  - Grants alternate I, D, I, D.
  - With ROUND_ROBIN=0, all four are I while i_read stays high.
- d_read rises during GRANT_I:
  - No change to address_o or read_o until I completes.
  - D is granted at resp+3.
- reset_n low for 1 cycle during GRANT_D_WR:
  - Next cycle read_o=0, write_o=0, address_o=0.
  - Following contention grants I first.
